// File: rtl/morse_capture.sv
// Morse key to right-aligned dot/dash letter patterns with a five-letter history.
// Define MORSE_WORD_GAP_EN to insert a 16'h0000 word separator after a long silence.
module morse_capture #(
  parameter int TICK_DIV   = 12500000,
  parameter int DEB_CYCLES = 500000,
  parameter int DASH_UNITS = 2,
  parameter int LETTER_GAP = 3,
  parameter int WORD_GAP   = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        key,
  input  logic        clear,
  output logic [15:0] morse1,
  output logic [15:0] morse2,
  output logic [15:0] morse3,
  output logic [15:0] morse4,
  output logic [15:0] morse5,
  output logic        letter_valid,
  output logic        overflow,
  output logic [1:0]  state_o
);

  localparam int TW = $clog2(TICK_DIV + 1);
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [3:0]    DASH_MIN  = 4'(DASH_UNITS);
  localparam logic [3:0]    LGAP_LAST = 4'(LETTER_GAP - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PRESS = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;
`ifdef MORSE_WORD_GAP_EN
  localparam logic [1:0] S_WGAP      = 2'd3;
  localparam logic [3:0] WGAP_LAST   = 4'(WORD_GAP - 1);
  localparam logic [1:0] S_AFTER_LTR = S_WGAP;
`else
  localparam logic [1:0] S_AFTER_LTR = S_IDLE;
`endif

  // Gap thresholds must fit the saturating 4-bit unit counter.
  if (LETTER_GAP < 1 || LETTER_GAP > 15 || WORD_GAP <= LETTER_GAP || WORD_GAP > 15) begin : g_bad_gap_cfg
    $error("morse_capture: LETTER_GAP/WORD_GAP out of range");
  end

  logic          sync1_q, sync2_q;
  logic [DW-1:0] deb_cnt_q;
  logic          key_db_q, key_db_prev_q;
  logic [TW-1:0] tick_cnt_q;
  logic [3:0]    units_q;
  logic          db_rise, db_fall, db_edge, tick;

  logic [1:0]  state_q, state_d;
  logic [15:0] pat_q, pat_d;
  logic [4:0]  len_q, len_d;
  logic        drop_q, drop_d;
  logic        overflow_q, overflow_d;
  logic        letter_valid_q, letter_valid_d;
  logic [15:0] slot_q [5];
  logic [15:0] slot_d [5];
  logic [2:0]  fill_q, fill_d;

  logic        sym_dash;
  logic [4:0]  sym_len;
  logic [15:0] sym_pat;
  logic        do_write;
  logic [15:0] wr_val;

  // Synchroniser and debouncer: unaffected by clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      deb_cnt_q     <= '0;
      key_db_q      <= 1'b0;
      key_db_prev_q <= 1'b0;
    end else begin
      sync1_q       <= key;
      sync2_q       <= sync1_q;
      key_db_prev_q <= key_db_q;
      if (sync2_q != key_db_q) begin
        if (deb_cnt_q == DEB_LAST) begin
          key_db_q  <= sync2_q;
          deb_cnt_q <= '0;
        end else begin
          deb_cnt_q <= deb_cnt_q + 1'b1;
        end
      end else begin
        deb_cnt_q <= '0;
      end
    end
  end

  assign db_rise = key_db_q & ~key_db_prev_q;
  assign db_fall = ~key_db_q & key_db_prev_q;
  assign db_edge = db_rise | db_fall;
  assign tick    = (tick_cnt_q == TICK_LAST);

  // Unit timing restarts on every debounced edge so units align to key transitions.
  always_ff @(posedge clk) begin
    if (reset || clear || db_edge) begin
      tick_cnt_q <= '0;
      units_q    <= '0;
    end else begin
      tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
      if (tick && units_q != 4'd15) units_q <= units_q + 1'b1;
    end
  end

  always_comb begin
    state_d        = state_q;
    pat_d          = pat_q;
    len_d          = len_q;
    drop_d         = drop_q;
    overflow_d     = overflow_q;
    letter_valid_d = 1'b0;
    fill_d         = fill_q;
    slot_d         = slot_q;
    do_write       = 1'b0;
    wr_val         = '0;
    sym_dash       = (units_q >= DASH_MIN);
    sym_len        = sym_dash ? 5'd4 : 5'd2;
    sym_pat        = sym_dash ? {pat_q[11:0], 4'b1110} : {pat_q[13:0], 2'b10};

    case (state_q)
      S_IDLE: if (db_rise) state_d = S_PRESS;
      S_PRESS: begin
        if (db_fall) begin
          if (len_q + sym_len > 5'd16) begin
            overflow_d = 1'b1;
            drop_d     = 1'b1;
          end else begin
            pat_d = sym_pat;
            len_d = len_q + sym_len;
          end
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (tick && units_q == LGAP_LAST) begin
          do_write = ~drop_q;
          wr_val   = pat_q;
          pat_d    = '0;
          len_d    = '0;
          drop_d   = 1'b0;
          state_d  = db_rise ? S_PRESS : S_AFTER_LTR;
        end else if (db_rise) begin
          state_d = S_PRESS;
        end
      end
`ifdef MORSE_WORD_GAP_EN
      S_WGAP: begin
        if (db_rise) begin
          state_d = S_PRESS;
        end else if (tick && units_q == WGAP_LAST) begin
          do_write = 1'b1;
          wr_val   = '0;
          state_d  = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Fill empty slots in order; once full, shift toward morse1.
    if (do_write) begin
      letter_valid_d = 1'b1;
      if (fill_q < 3'd5) begin
        for (int i = 0; i < 5; i++) begin
          if (fill_q == 3'(i)) slot_d[i] = wr_val;
        end
        fill_d = fill_q + 1'b1;
      end else begin
        for (int i = 0; i < 4; i++) slot_d[i] = slot_q[i+1];
        slot_d[4] = wr_val;
      end
    end

    if (clear) begin
      state_d        = key_db_q ? S_PRESS : S_IDLE;
      pat_d          = '0;
      len_d          = '0;
      drop_d         = 1'b0;
      overflow_d     = 1'b0;
      letter_valid_d = 1'b0;
      fill_d         = '0;
      for (int i = 0; i < 5; i++) slot_d[i] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      pat_q          <= '0;
      len_q          <= '0;
      drop_q         <= 1'b0;
      overflow_q     <= 1'b0;
      letter_valid_q <= 1'b0;
      fill_q         <= '0;
      for (int i = 0; i < 5; i++) slot_q[i] <= '0;
    end else begin
      state_q        <= state_d;
      pat_q          <= pat_d;
      len_q          <= len_d;
      drop_q         <= drop_d;
      overflow_q     <= overflow_d;
      letter_valid_q <= letter_valid_d;
      fill_q         <= fill_d;
      for (int i = 0; i < 5; i++) slot_q[i] <= slot_d[i];
    end
  end

  assign morse1       = slot_q[0];
  assign morse2       = slot_q[1];
  assign morse3       = slot_q[2];
  assign morse4       = slot_q[3];
  assign morse5       = slot_q[4];
  assign letter_valid = letter_valid_q;
  assign overflow     = overflow_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_morse_capture.sv
// Directed bench for morse_capture: letter table plus hand-written corner sequences.
module tb_morse_capture;

  localparam int TICK_DIV   = 4;
  localparam int DEB_CYCLES = 2;
  localparam int DASH_UNITS = 2;
  localparam int LETTER_GAP = 3;
  localparam int WORD_GAP   = 7;
  localparam int UNIT       = TICK_DIV;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PRESS = 2'd1;

  logic        clk = 1'b0;
  logic        reset, key, clear;
  logic [15:0] morse1, morse2, morse3, morse4, morse5;
  logic        letter_valid, overflow;
  logic [1:0]  state_o;

  int checks    = 0;
  int errors    = 0;
  int pulse_cnt = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    int          nsym;
    logic [7:0]  dash;   // bit i set: symbol i is a dash (first symbol = bit 0)
    logic [15:0] m1, m2, m3, m4, m5;
  } vec_t;
  vec_t vecs[6];

  morse_capture #(
    .TICK_DIV(TICK_DIV), .DEB_CYCLES(DEB_CYCLES), .DASH_UNITS(DASH_UNITS),
    .LETTER_GAP(LETTER_GAP), .WORD_GAP(WORD_GAP)
  ) dut (
    .clk(clk), .reset(reset), .key(key), .clear(clear),
    .morse1(morse1), .morse2(morse2), .morse3(morse3), .morse4(morse4), .morse5(morse5),
    .letter_valid(letter_valid), .overflow(overflow), .state_o(state_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (letter_valid) pulse_cnt++;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_slots(input string tag, input logic [15:0] e1, input logic [15:0] e2,
                             input logic [15:0] e3, input logic [15:0] e4, input logic [15:0] e5);
    logic [15:0] act [5];
    act[0] = morse1; act[1] = morse2; act[2] = morse3; act[3] = morse4; act[4] = morse5;
    exp_q.push_back(e1); exp_q.push_back(e2); exp_q.push_back(e3);
    exp_q.push_back(e4); exp_q.push_back(e5);
    for (int i = 0; i < 5; i++) check($sformatf("%s morse%0d", tag, i + 1), act[i], exp_q.pop_front());
  endtask

  task automatic send_letter(input int nsym, input logic [7:0] dash, input int end_units);
    for (int i = 0; i < nsym; i++) begin
      key = 1'b1;
      step(dash[i] ? 3 * UNIT : UNIT);
      key = 1'b0;
      step((i == nsym - 1) ? end_units * UNIT : UNIT);
    end
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step(1);
    clear = 1'b0;
  endtask

  initial begin
    int p0;
    int bad;

    vecs[0] = '{1, 8'h00, 16'h0002, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vecs[1] = '{1, 8'h01, 16'h0002, 16'h000E, 16'h0000, 16'h0000, 16'h0000};
    vecs[2] = '{2, 8'h00, 16'h0002, 16'h000E, 16'h000A, 16'h0000, 16'h0000};
    vecs[3] = '{3, 8'h00, 16'h0002, 16'h000E, 16'h000A, 16'h002A, 16'h0000};
    vecs[4] = '{4, 8'h00, 16'h0002, 16'h000E, 16'h000A, 16'h002A, 16'h00AA};
    vecs[5] = '{2, 8'h02, 16'h000E, 16'h000A, 16'h002A, 16'h00AA, 16'h002E};

    // Reset and idle
    reset = 1'b1; key = 1'b0; clear = 1'b0;
    step(3);
    reset = 1'b0;
    check("reset state", {14'd0, state_o}, {14'd0, ST_IDLE});
    check_slots("reset", 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    check("reset letter_valid", {15'd0, letter_valid}, 16'h0);
    check("reset overflow", {15'd0, overflow}, 16'h0);
    step(100);
    check_slots("idle", 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    check("idle pulses", 16'(pulse_cnt), 16'h0);

    // Single letter "a"
    p0 = pulse_cnt;
    send_letter(2, 8'h02, 4);
    step(8);
    check_slots("a", 16'h002E, 16'h0, 16'h0, 16'h0, 16'h0);
    check("a pulses", 16'(pulse_cnt - p0), 16'd1);

    // Table: e t i s h fill the slots, a shifts
    pulse_clear();
    for (int v = 0; v < 6; v++) begin
      p0 = pulse_cnt;
      send_letter(vecs[v].nsym, vecs[v].dash, 4);
      step(8);
      check_slots($sformatf("vec%0d", v), vecs[v].m1, vecs[v].m2, vecs[v].m3, vecs[v].m4, vecs[v].m5);
      check($sformatf("vec%0d pulses", v), 16'(pulse_cnt - p0), 16'd1);
      check($sformatf("vec%0d overflow", v), {15'd0, overflow}, 16'h0);
    end

    // Overflow: five dashes dropped, next letter kept, clear wipes
    pulse_clear();
    p0 = pulse_cnt;
    send_letter(5, 8'h1F, 4);
    step(8);
    check("ovf flag", {15'd0, overflow}, 16'h1);
    check_slots("ovf", 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    check("ovf pulses", 16'(pulse_cnt - p0), 16'd0);
    send_letter(1, 8'h00, 4);
    step(8);
    check_slots("ovf e", 16'h0002, 16'h0, 16'h0, 16'h0, 16'h0);
    check("ovf sticky", {15'd0, overflow}, 16'h1);
    check("ovf e pulses", 16'(pulse_cnt - p0), 16'd1);
    pulse_clear();
    check_slots("clear", 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    check("clear overflow", {15'd0, overflow}, 16'h0);

    // One-cycle glitches during silence must be filtered
    p0 = pulse_cnt;
    bad = 0;
    repeat (10) begin
      key = 1'b1;
      step(1);
      key = 1'b0;
      repeat (3) begin
        step(1);
        if (state_o != ST_IDLE) bad++;
      end
    end
    step(6 * UNIT);
    check("glitch state excursions", 16'(bad), 16'd0);
    check("glitch state", {14'd0, state_o}, {14'd0, ST_IDLE});
    check("glitch pulses", 16'(pulse_cnt - p0), 16'd0);
    check_slots("glitch", 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);

    // Reset in the middle of a press
    send_letter(1, 8'h00, 4);
    step(8);
    check_slots("pre-reset", 16'h0002, 16'h0, 16'h0, 16'h0, 16'h0);
    key = 1'b1;
    step(10);
    check("press state", {14'd0, state_o}, {14'd0, ST_PRESS});
    reset = 1'b1;
    key   = 1'b0;
    step(1);
    check_slots("mid reset", 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    check("mid reset state", {14'd0, state_o}, {14'd0, ST_IDLE});
    check("mid reset overflow", {15'd0, overflow}, 16'h0);
    check("mid reset letter_valid", {15'd0, letter_valid}, 16'h0);
    reset = 1'b0;
    step(40);
    check_slots("post reset", 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    check("post reset state", {14'd0, state_o}, {14'd0, ST_IDLE});

    // Word gap: "e", 8 units silence, "t"
    pulse_clear();
    p0 = pulse_cnt;
    send_letter(1, 8'h00, 8);
    send_letter(1, 8'h01, 4);
    step(8);
`ifdef MORSE_WORD_GAP_EN
    check_slots("word gap", 16'h0002, 16'h0000, 16'h000E, 16'h0, 16'h0);
    check("word gap pulses", 16'(pulse_cnt - p0), 16'd3);
`else
    check_slots("word gap", 16'h0002, 16'h000E, 16'h0, 16'h0, 16'h0);
    check("word gap pulses", 16'(pulse_cnt - p0), 16'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
